// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-flow types, game-over codes and screen codes
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESTART   = 3'd1,
        GRACE     = 3'd2,
        PLAY      = 3'd3,
        TOM_WIN   = 3'd4,
        JERRY_WIN = 3'd5,
        MATCH_END = 3'd6
    } game_state_t;

    // Game-over codes shared with the upstream detector; 2'b11 is treated as GO_CAUGHT.
    localparam logic [1:0] GO_NONE   = 2'b00;
    localparam logic [1:0] GO_CHEESE = 2'b01;
    localparam logic [1:0] GO_CAUGHT = 2'b10;

    localparam logic [1:0] SCR_TITLE = 2'b00;
    localparam logic [1:0] SCR_GAME  = 2'b01;
    localparam logic [1:0] SCR_TOM   = 2'b10;
    localparam logic [1:0] SCR_JERRY = 2'b11;

    // Screen shown while in state st; MATCH_END keeps whichever banner is up.
    function automatic logic [1:0] screen_for(input game_state_t st, input logic [1:0] cur);
        case (st)
            IDLE:                   screen_for = SCR_TITLE;
            RESTART, GRACE, PLAY:   screen_for = SCR_GAME;
            TOM_WIN:                screen_for = SCR_TOM;
            JERRY_WIN:              screen_for = SCR_JERRY;
            MATCH_END:              screen_for = cur;
            default:                screen_for = SCR_TITLE;
        endcase
    endfunction

endpackage

// File: rtl/frame_counter.sv
// rtl/frame_counter.sv - frame_tick counter with sync clear, saturation and done flag
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous clear to zero (has priority over tick)
//   tick       : count enable, one pulse per frame
//   limit      : saturation value
//   done       : count has reached limit, or reaches it with this cycle's tick
module frame_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count;
    logic [W:0]   count_inc;

    assign count_inc = {1'b0, count} + (W+1)'(1);

    // done looks one tick ahead so a tick and a dependent event in the same
    // cycle are handled as "tick first, then event".
    assign done = (count >= limit) || (tick && (count_inc >= {1'b0, limit}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count < limit)) begin
            count <= count_inc[W-1:0];
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - round life-cycle controller downstream of the game-over detector
//   clk, rst    : clock, asynchronous active-high reset
//   gameover    : registered game-over code from the detector
//   start_btn   : start/continue key level
//   frame_tick  : one pulse per video frame
//   play_en     : movement enable, high in GRACE and PLAY
//   restart     : one-cycle re-seed pulse
//   state       : current game_state_t
//   screen_sel  : display mux select
//   tom_score   : Tom round wins
//   jerry_score : Jerry round wins
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int HOLD_FRAMES  = 120,
    parameter int GRACE_FRAMES = 2,
    parameter int MAX_SCORE    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  gameover,
    input  logic        start_btn,
    input  logic        frame_tick,
    output logic        play_en,
    output logic        restart,
    output game_state_t state,
    output logic [1:0]  screen_sel,
    output logic [3:0]  tom_score,
    output logic [3:0]  jerry_score
);

    localparam int CNT_MAX = (HOLD_FRAMES > GRACE_FRAMES) ? HOLD_FRAMES : GRACE_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [3:0] MAX_S = 4'(MAX_SCORE);

    logic        start_d;
    logic        start_armed;
    logic        start_edge;
    logic        cnt_clear;
    logic        cnt_done;
    logic [CW-1:0] cnt_limit;
    logic        tom_hit;
    logic        jerry_hit;
    game_state_t nxt;

    // start_armed stays low until the button has been seen released after
    // reset, so a key held through reset release yields no edge.
    assign start_edge = start_btn && !start_d && start_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d     <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            start_d <= start_btn;
            if (!start_btn) begin
                start_armed <= 1'b1;
            end
        end
    end

    // One counter times both GRACE and the result-screen hold.
    assign cnt_limit = (state == GRACE) ? CW'(GRACE_FRAMES) : CW'(HOLD_FRAMES);
    assign cnt_clear = (state == IDLE) || (state == RESTART) ||
                       (state == PLAY) || (state == MATCH_END);

    frame_counter #(.W(CW)) u_frame_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .tick  (frame_tick),
        .limit (cnt_limit),
        .done  (cnt_done)
    );

    // Code 11 is treated like GO_CAUGHT, so bit 1 alone marks a Tom win.
    assign tom_hit   = gameover[1];
    assign jerry_hit = (gameover == GO_CHEESE);

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:      nxt = start_edge ? RESTART : IDLE;
            RESTART:   nxt = GRACE;
            GRACE:     nxt = cnt_done ? PLAY : GRACE;
            PLAY: begin
                if (tom_hit) begin
                    nxt = TOM_WIN;
                end else if (jerry_hit) begin
                    nxt = JERRY_WIN;
                end else begin
                    nxt = PLAY;
                end
            end
            TOM_WIN: begin
                if (start_edge && cnt_done) begin
                    nxt = (tom_score == MAX_S) ? MATCH_END : RESTART;
                end else begin
                    nxt = TOM_WIN;
                end
            end
            JERRY_WIN: begin
                if (start_edge && cnt_done) begin
                    nxt = (jerry_score == MAX_S) ? MATCH_END : RESTART;
                end else begin
                    nxt = JERRY_WIN;
                end
            end
            MATCH_END: nxt = start_edge ? IDLE : MATCH_END;
            default:   nxt = IDLE;
        endcase
    end

    // All outputs are registered from the next state so they move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            play_en     <= 1'b0;
            restart     <= 1'b0;
            screen_sel  <= SCR_TITLE;
            tom_score   <= 4'd0;
            jerry_score <= 4'd0;
        end else begin
            state      <= nxt;
            play_en    <= (nxt == GRACE) || (nxt == PLAY);
            restart    <= (nxt == RESTART);
            screen_sel <= screen_for(nxt, screen_sel);
            if (state == PLAY && nxt == TOM_WIN) begin
                tom_score <= tom_score + 4'd1;
            end
            if (state == PLAY && nxt == JERRY_WIN) begin
                jerry_score <= jerry_score + 4'd1;
            end
            if (state == MATCH_END && nxt == IDLE) begin
                tom_score   <= 4'd0;
                jerry_score <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gameover = 2'b00;
    logic       start_btn = 1'b1;
    logic       frame_tick = 1'b0;
    logic       play_en;
    logic       restart;
    logic [2:0] state;
    logic [1:0] screen_sel;
    logic [3:0] tom_score;
    logic [3:0] jerry_score;

    int n_cmp = 0;
    int n_bad = 0;

    game_flow_ctrl #(
        .HOLD_FRAMES  (120),
        .GRACE_FRAMES (2),
        .MAX_SCORE    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gameover    (gameover),
        .start_btn   (start_btn),
        .frame_tick  (frame_tick),
        .play_en     (play_en),
        .restart     (restart),
        .state       (state),
        .screen_sel  (screen_sel),
        .tom_score   (tom_score),
        .jerry_score (jerry_score)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press();
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
    endtask

    // Entered right after the RESTART pulse: GRACE, two ticks, one PLAY cycle with code.
    task automatic run_round(input logic [1:0] code);
        cyc(1);
        ticks(2);
        gameover = code;
        cyc(1);
        gameover = 2'b00;
    endtask

    initial begin
        cyc(3);
        check_val("rst_state", 8'(state), 8'd0);
        check_val("rst_play_en", 8'(play_en), 8'd0);
        check_val("rst_restart", 8'(restart), 8'd0);
        check_val("rst_screen", 8'(screen_sel), 8'd0);
        check_val("rst_scores", {tom_score, jerry_score}, 8'h00);

        // Key held through reset release must not start a game.
        rst = 1'b0;
        cyc(3);
        check_val("held_no_edge", 8'(state), 8'd0);
        start_btn = 1'b0;
        cyc(1);
        press();
        check_val("restart_state", 8'(state), 8'd1);
        check_val("restart_pulse", 8'(restart), 8'd1);
        cyc(1);
        check_val("grace_state", 8'(state), 8'd2);
        check_val("restart_one_cycle", 8'(restart), 8'd0);
        check_val("grace_play_en", 8'(play_en), 8'd1);
        check_val("grace_screen", 8'(screen_sel), 8'd1);
        tick();
        check_val("grace_after_1tick", 8'(state), 8'd2);
        tick();
        check_val("play_after_2ticks", 8'(state), 8'd3);
        cyc(2);
        check_val("play_stays", 8'(state), 8'd3);
        gameover = 2'b10;
        cyc(1);
        gameover = 2'b00;
        check_val("tom_win_state", 8'(state), 8'd4);
        check_val("tom_score_1", 8'(tom_score), 8'd1);
        check_val("tom_screen", 8'(screen_sel), 8'd2);
        check_val("win_play_en", 8'(play_en), 8'd0);

        // Edge at tick 119 is dropped, not queued.
        ticks(119);
        press();
        check_val("early_edge_ignored", 8'(state), 8'd4);
        cyc(1);
        tick();
        check_val("no_queued_edge", 8'(state), 8'd4);
        press();
        check_val("hold_done_restart", 8'(restart), 8'd1);
        check_val("hold_done_state", 8'(state), 8'd1);

        // Jerry code during GRACE is ignored, acted on once in PLAY.
        cyc(1);
        gameover = 2'b01;
        tick();
        check_val("grace_ignores_go", 8'(jerry_score), 8'd0);
        tick();
        check_val("grace_to_play_go", 8'(state), 8'd3);
        check_val("grace_to_play_jerry", 8'(jerry_score), 8'd0);
        cyc(1);
        gameover = 2'b00;
        check_val("jerry_win_state", 8'(state), 8'd5);
        check_val("jerry_score_1", 8'(jerry_score), 8'd1);
        check_val("jerry_screen", 8'(screen_sel), 8'd3);
        check_val("tom_unchanged", 8'(tom_score), 8'd1);

        // Key held across the hold expiry produces no restart.
        start_btn = 1'b1;
        cyc(1);
        ticks(120);
        cyc(2);
        check_val("held_across_expiry", 8'(state), 8'd5);
        start_btn = 1'b0;
        cyc(1);
        press();
        check_val("release_press_restart", 8'(restart), 8'd1);

        run_round(2'b10);
        check_val("tom_score_2", 8'(tom_score), 8'd2);

        // Final hold tick and key edge in the same cycle are both honoured.
        ticks(119);
        frame_tick = 1'b1;
        start_btn = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        start_btn = 1'b0;
        check_val("tick_and_edge_same_cycle", 8'(state), 8'd1);

        run_round(2'b11);
        check_val("tom_score_3", 8'(tom_score), 8'd3);
        ticks(120);
        press();
        cyc(1);
        ticks(2);
        check_val("play_before_rst", 8'(state), 8'd3);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #3;
        rst = 1'b1;
        #1;
        check_val("async_rst_state", 8'(state), 8'd0);
        check_val("async_rst_scores", {tom_score, jerry_score}, 8'h00);
        check_val("async_rst_play_en", 8'(play_en), 8'd0);
        check_val("async_rst_screen", 8'(screen_sel), 8'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check_val("no_restart_after_rst", 8'(restart), 8'd0);

        press();
        run_round(2'b11);
        check_val("go11_tom_win", 8'(tom_score), 8'd1);
        check_val("go11_state", 8'(state), 8'd4);
        for (int r = 2; r <= 4; r++) begin
            ticks(120);
            press();
            run_round(2'b10);
        end
        check_val("tom_score_max", 8'(tom_score), 8'd4);
        ticks(120);
        press();
        check_val("match_end_state", 8'(state), 8'd6);
        check_val("match_end_screen", 8'(screen_sel), 8'd2);
        check_val("match_end_play_en", 8'(play_en), 8'd0);
        check_val("match_end_restart", 8'(restart), 8'd0);
        cyc(1);
        press();
        check_val("back_to_idle", 8'(state), 8'd0);
        check_val("scores_cleared", {tom_score, jerry_score}, 8'h00);
        check_val("idle_screen", 8'(screen_sel), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
